serial_alu_sched: RTL and testbench
===================================

# serial_alu_sched

Two-requester scheduler and sequencer for the bit-serial 4-bit ALU datapath. It accepts operations from two independent requesters over valid/ready handshakes and arbitrates between them round-robin. It runs the granted operation LSB-first, one bit per clock, through an internal bit-serial add/sub/and/xor engine, then returns the result and flags tagged with the requester id. It sits between the instruction-issue logic of two clients and the shared serial ALU resource.

## Interface
- WIDTH, default 4: operand width and number of bit-serial cycles per operation (legal values 2..16)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- req0_valid  in  1  requester 0 has an operation pending
- req0_ready  out  1  requester 0 operation accepted this cycle
- req0_a, req0_b  in  WIDTH  requester 0 operands
- req0_op  in  3  requester 0 opcode
- req1_valid, req1_ready, req1_a, req1_b, req1_op: same as requester 0, for requester 1
- rsp_valid  out  1  one-cycle result strobe
- rsp_id  out  1  requester that owns the result
- rsp_c  out  WIDTH  result
- rsp_carry, rsp_sign, rsp_zero, rsp_err  out  1 each  result flags
- busy  out  1  state is not IDLE

## Operation
- Opcodes:
  - 000 NOP: C=0
  - 001 XOR
  - 010 ADD
  - 011 AND
  - 100 SUB
  - 101–111 illegal
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on acceptance. Operands, op and id are captured, and bit index = 0.
  - RUN processes bit[idx] on each edge. The edge that processes idx=WIDTH-1 moves to DONE.
  - DONE→IDLE unconditionally after one cycle.
- Arbitration happens only in IDLE.
  - If exactly one requester is valid, that requester is granted.
  - If both are valid, the requester ≠ last_id is granted.
  - last_id updates on acceptance and resets to 1, so requester 0 wins the first tie.
- Handshake:
  - reqN_ready = (state==IDLE) & reqN_valid & granted(N). It is combinational and forced 0 while rst_n is low.
  - Transfer happens when valid and ready are both high at a rising edge.
  - A requester holds valid, a, b and op stable until accepted.
  - At most one ready is high in any cycle.
- Bit-serial engine: 1-bit carry/borrow register, cleared at acceptance.
  - ADD: sum = a[i]+b[i]+cy. c[i] = sum[0]; cy = carry out of the bit.
  - SUB: c[i] = a[i]^b[i]^bw; bw = (~a[i]&b[i]) | (~(a[i]^b[i])&bw).
  - AND and XOR are bitwise; cy is held at 0.
  - NOP and illegal opcodes produce c[i] = 0.
- Flags are registered at entry to DONE and describe the full WIDTH-bit result:
  - rsp_carry: final carry (ADD), final borrow (SUB, 1 iff a<b unsigned), otherwise 0.
  - rsp_zero = (C==0); rsp_sign = C[WIDTH-1].
  - rsp_err = 1 only for illegal opcodes.
- Every opcode, including NOP and illegal, takes the full WIDTH cycles.
- The response has no backpressure. The consumer must sample rsp_* while rsp_valid is high.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_id 0, rsp_c 0, rsp_carry 0, rsp_sign 0, rsp_zero 0, rsp_err 0, busy 0, last_id 1, carry/borrow register 0. Both readies are 0 while rst_n is low.
- Latency: with acceptance at edge T, the state enters DONE at edge T+WIDTH. rsp_valid is high for exactly the cycle between edges T+WIDTH and T+WIDTH+1.
- rsp_c and the flags hold their values after rsp_valid falls, until the next DONE.
- The next acceptance can occur at edge T+WIDTH+2, giving a throughput of one op per WIDTH+2 cycles.
- busy is high from edge T to edge T+WIDTH+1.
- Valid rising during RUN or DONE is ignored until IDLE. The arbitration winner is decided by the valids present in the IDLE cycle.
- Reset asserted mid-operation clears all state immediately. The in-flight op is discarded and produces no rsp_valid. A requester still holding valid is re-arbitrated after rst_n deasserts, with requester 0 winning a tie.
- Operand changes after acceptance do not affect the running op.

## Test plan
- req0 ADD a=0111 b=0011, accepted at T → at T+4: rsp_valid=1 for one cycle, rsp_id=0, C=1010, carry=0, sign=1, zero=0, err=0. Then req0 ADD 1111+0001 → C=0000, carry=1, zero=1.
- req1 SUB a=0011 b=0101 → C=1110, carry(borrow)=1, sign=1, zero=0, rsp_id=1. Then SUB 0101-0101 → C=0000, carry=0, zero=1.
- After reset, both valid in the same cycle (req0 AND 0110&0110, req1 XOR 1010^1010):
  - req0_ready is high at T and req1_ready is low.
  - req0 response: C=0110, id 0.
  - req1 is accepted at T+6; its response is C=0000, zero=1, id 1.
  - busy drops for exactly one cycle between the two ops.
- Both requesters hold valid continuously for 6 ops → grants alternate 0,1,0,1,0,1, and each rsp_id matches the granted requester.
- req0 op=111, a=1111, b=1111 → at T+4: err=1, C=0000, carry=0, zero=1, sign=0. Then op=000 → C=0000, err=0.
- Fault injection: req0 ADD accepted at T, rst_n pulled low at T+2 for 1 cycle with valid held → no rsp_valid and busy=0 during reset. The op is re-accepted on the first edge after release, and a full correct response arrives 4 cycles later.

Source files
------------

// File: rtl/serial_alu_sched_if.sv
// Request/response bundle between the two ALU clients and the serial ALU scheduler.
// The master side is the client pair; the slave side is the scheduler.
interface serial_alu_sched_if #(
  parameter int unsigned WIDTH = 4
);
  logic             req0_valid;
  logic             req0_ready;
  logic [WIDTH-1:0] req0_a;
  logic [WIDTH-1:0] req0_b;
  logic [2:0]       req0_op;
  logic             req1_valid;
  logic             req1_ready;
  logic [WIDTH-1:0] req1_a;
  logic [WIDTH-1:0] req1_b;
  logic [2:0]       req1_op;
  logic             rsp_valid;
  logic             rsp_id;
  logic [WIDTH-1:0] rsp_c;
  logic             rsp_carry;
  logic             rsp_sign;
  logic             rsp_zero;
  logic             rsp_err;

  modport master (
    output req0_valid, req0_a, req0_b, req0_op,
    output req1_valid, req1_a, req1_b, req1_op,
    input  req0_ready, req1_ready,
    input  rsp_valid, rsp_id, rsp_c, rsp_carry, rsp_sign, rsp_zero, rsp_err
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_op,
    input  req1_valid, req1_a, req1_b, req1_op,
    output req0_ready, req1_ready,
    output rsp_valid, rsp_id, rsp_c, rsp_carry, rsp_sign, rsp_zero, rsp_err
  );
endinterface

// File: rtl/serial_alu_sched.sv
// Round-robin scheduler for two requesters feeding a bit-serial add/sub/and/xor engine.
// Each op runs LSB-first, one bit per clock, and returns a tagged one-cycle response.
module serial_alu_sched #(
  parameter int unsigned WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  serial_alu_sched_if.slave  bus,
  output logic               busy
);
  localparam int unsigned IW = $clog2(WIDTH);

  localparam logic [2:0] OP_XOR = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_SUB = 3'b100;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] c_r;
  logic [2:0]       op_r;
  logic             id_r;
  logic             last_id;
  logic             cy;
  logic [IW-1:0]    idx;

  logic             grant0;
  logic             grant1;
  logic             abit;
  logic             bbit;
  logic             cbit;
  logic             cy_n;
  logic [WIDTH-1:0] res;

  // On a tie the requester that did not win last time is granted.
  always_comb begin
    grant0 = bus.req0_valid & (~bus.req1_valid | last_id);
    grant1 = bus.req1_valid & (~bus.req0_valid | ~last_id);
  end

  assign bus.req0_ready = rst_n & (state == IDLE) & grant0;
  assign bus.req1_ready = rst_n & (state == IDLE) & grant1;
  assign busy           = (state != IDLE);

  always_comb begin
    abit = a_r[idx];
    bbit = b_r[idx];
    cbit = 1'b0;
    cy_n = 1'b0;
    case (op_r)
      OP_XOR: cbit = abit ^ bbit;
      OP_ADD: begin
        cbit = abit ^ bbit ^ cy;
        cy_n = (abit & bbit) | (cy & (abit ^ bbit));
      end
      OP_AND: cbit = abit & bbit;
      OP_SUB: begin
        cbit = abit ^ bbit ^ cy;
        cy_n = (~abit & bbit) | (~(abit ^ bbit) & cy);
      end
      default: begin
        cbit = 1'b0;
        cy_n = 1'b0;
      end
    endcase
    res      = c_r;
    res[idx] = cbit;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      a_r           <= '0;
      b_r           <= '0;
      c_r           <= '0;
      op_r          <= '0;
      id_r          <= 1'b0;
      last_id       <= 1'b1;
      cy            <= 1'b0;
      idx           <= '0;
      bus.rsp_valid <= 1'b0;
      bus.rsp_id    <= 1'b0;
      bus.rsp_c     <= '0;
      bus.rsp_carry <= 1'b0;
      bus.rsp_sign  <= 1'b0;
      bus.rsp_zero  <= 1'b0;
      bus.rsp_err   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req0_ready || bus.req1_ready) begin
            a_r     <= bus.req1_ready ? bus.req1_a  : bus.req0_a;
            b_r     <= bus.req1_ready ? bus.req1_b  : bus.req0_b;
            op_r    <= bus.req1_ready ? bus.req1_op : bus.req0_op;
            id_r    <= bus.req1_ready;
            last_id <= bus.req1_ready;
            c_r     <= '0;
            cy      <= 1'b0;
            idx     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          c_r <= res;
          cy  <= cy_n;
          idx <= idx + IW'(1);
          // Flags come from the combinational view so they include the final bit.
          if (idx == IW'(WIDTH - 1)) begin
            state         <= DONE;
            bus.rsp_valid <= 1'b1;
            bus.rsp_id    <= id_r;
            bus.rsp_c     <= res;
            bus.rsp_carry <= cy_n;
            bus.rsp_sign  <= res[WIDTH-1];
            bus.rsp_zero  <= (res == '0);
            bus.rsp_err   <= (op_r > OP_SUB);
          end
        end
        DONE: begin
          bus.rsp_valid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_serial_alu_sched.sv
// Randomized bench for serial_alu_sched against an arithmetic reference model.
module tb_serial_alu_sched;
  localparam int unsigned W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  always #5 clk = ~clk;

  serial_alu_sched_if #(.WIDTH(W)) bus ();

  serial_alu_sched #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  typedef struct {
    logic         id;
    logic [W-1:0] c;
    logic         carry;
    logic         sign;
    logic         zero;
    logic         err;
    int           acc;
  } exp_t;

  exp_t q[$];
  exp_t last_e = '{default: 0};
  int   gnt_log[$];
  int   cyc = 0;
  int   acc_cyc = -100;
  logic lid = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h at cyc %0d", tag, got, exp, cyc);
    end
  endtask

  function automatic exp_t model(input logic id, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [2:0] op, input int acc);
    exp_t e;
    logic [W:0] s;
    e.id = id; e.acc = acc; e.c = '0; e.carry = 1'b0; e.err = 1'b0;
    case (op)
      3'd0: e.c = '0;
      3'd1: e.c = a ^ b;
      3'd2: begin s = {1'b0, a} + {1'b0, b}; e.c = s[W-1:0]; e.carry = s[W]; end
      3'd3: e.c = a & b;
      3'd4: begin e.c = a - b; e.carry = (a < b); end
      default: e.err = 1'b1;
    endcase
    e.sign = e.c[W-1];
    e.zero = (e.c == '0);
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    exp_t e;
    logic bexp, r0e, r1e;
    if (!rst_n) begin
      check("rst_ready0", bus.req0_ready, 0);
      check("rst_ready1", bus.req1_ready, 0);
      check("rst_busy", busy, 0);
      check("rst_rsp_valid", bus.rsp_valid, 0);
      check("rst_rsp_c", bus.rsp_c, 0);
      check("rst_flags", {bus.rsp_id, bus.rsp_carry, bus.rsp_sign, bus.rsp_zero, bus.rsp_err}, 0);
      q.delete();
      acc_cyc = -100;
      lid = 1'b1;
      last_e = '{default: 0};
    end else begin
      if (bus.rsp_valid) begin
        if (q.size() == 0) begin
          check("rsp_spurious", 1, 0);
        end else begin
          e = q.pop_front();
          check("rsp_id", bus.rsp_id, e.id);
          check("rsp_c", bus.rsp_c, e.c);
          check("rsp_carry", bus.rsp_carry, e.carry);
          check("rsp_sign", bus.rsp_sign, e.sign);
          check("rsp_zero", bus.rsp_zero, e.zero);
          check("rsp_err", bus.rsp_err, e.err);
          check("rsp_latency", cyc - e.acc, W + 1);
          last_e = e;
        end
      end else begin
        check("hold_c", bus.rsp_c, last_e.c);
        check("hold_flags", {bus.rsp_id, bus.rsp_carry, bus.rsp_sign, bus.rsp_zero, bus.rsp_err},
              {last_e.id, last_e.carry, last_e.sign, last_e.zero, last_e.err});
      end
      // One op occupies the engine from the accepting edge until WIDTH+1 edges later.
      bexp = (cyc >= acc_cyc + 1) && (cyc <= acc_cyc + int'(W) + 1);
      check("busy", busy, bexp);
      r0e = !bexp && bus.req0_valid && (!bus.req1_valid || lid);
      r1e = !bexp && bus.req1_valid && (!bus.req0_valid || !lid);
      check("ready0", bus.req0_ready, r0e);
      check("ready1", bus.req1_ready, r1e);
      if (bus.req0_ready && bus.req0_valid) begin
        q.push_back(model(1'b0, bus.req0_a, bus.req0_b, bus.req0_op, cyc));
        acc_cyc = cyc; lid = 1'b0; gnt_log.push_back(0);
      end else if (bus.req1_ready && bus.req1_valid) begin
        q.push_back(model(1'b1, bus.req1_a, bus.req1_b, bus.req1_op, cyc));
        acc_cyc = cyc; lid = 1'b1; gnt_log.push_back(1);
      end
    end
  end

  task automatic issue(input int n, input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
    bit ok;
    ok = 1'b0;
    if (n == 0) begin bus.req0_a = a; bus.req0_b = b; bus.req0_op = op; bus.req0_valid = 1'b1; end
    else        begin bus.req1_a = a; bus.req1_b = b; bus.req1_op = op; bus.req1_valid = 1'b1; end
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if ((n == 0) ? bus.req0_ready : bus.req1_ready) begin ok = 1'b1; break; end
    end
    if (!ok) check("issue_timeout", 0, 1);
    @(posedge clk); #1;
    if (n == 0) bus.req0_valid = 1'b0; else bus.req1_valid = 1'b0;
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < int'(W) + 8; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) return;
    end
    check("rsp_timeout", 0, 1);
  endtask

  task automatic do_reset();
    @(posedge clk); #3 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    bit ok;
    int mode;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0; bus.req0_op = '0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0; bus.req1_op = '0;
    bus.req0_valid = 1'b1;
    repeat (3) @(posedge clk);
    bus.req0_valid = 1'b0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;

    issue(0, 4'b0111, 4'b0011, 3'd2); wait_rsp();
    check("tp_add_c", bus.rsp_c, 4'b1010);
    check("tp_add_flags", {bus.rsp_carry, bus.rsp_sign, bus.rsp_zero, bus.rsp_err}, 4'b0100);
    issue(0, 4'b1111, 4'b0001, 3'd2); wait_rsp();
    check("tp_add_wrap", {bus.rsp_carry, bus.rsp_zero, bus.rsp_c}, 6'b110000);
    issue(1, 4'b0011, 4'b0101, 3'd4); wait_rsp();
    check("tp_sub_c", bus.rsp_c, 4'b1110);
    check("tp_sub_flags", {bus.rsp_id, bus.rsp_carry, bus.rsp_sign, bus.rsp_zero}, 4'b1110);
    issue(1, 4'b0101, 4'b0101, 3'd4);
    issue(0, 4'b1111, 4'b1111, 3'd7); wait_rsp();
    check("tp_illegal", {bus.rsp_err, bus.rsp_carry, bus.rsp_zero, bus.rsp_sign, bus.rsp_c}, 8'b10100000);
    issue(0, 4'b1111, 4'b1111, 3'd0); wait_rsp();
    check("tp_nop", {bus.rsp_err, bus.rsp_c}, 5'b00000);

    do_reset();
    gnt_log.delete();
    fork
      issue(0, 4'b0110, 4'b0110, 3'd3);
      issue(1, 4'b1010, 4'b1010, 3'd1);
    join
    repeat (W + 3) @(posedge clk); #1;
    check("tie_count", gnt_log.size(), 2);
    if (gnt_log.size() == 2) begin
      check("tie_first", gnt_log[0], 0);
      check("tie_second", gnt_log[1], 1);
    end

    gnt_log.delete();
    fork
      for (int i = 0; i < 3; i++) issue(0, W'($urandom), W'($urandom), 3'($urandom_range(7, 0)));
      for (int j = 0; j < 3; j++) issue(1, W'($urandom), W'($urandom), 3'($urandom_range(7, 0)));
    join
    check("alt_count", gnt_log.size(), 6);
    for (int k = 0; k < gnt_log.size(); k++) check("alt_grant", gnt_log[k], k % 2);

    // Reset in the middle of an op with valid still held.
    bus.req0_a = 4'b1001; bus.req0_b = 4'b1000; bus.req0_op = 3'd2; bus.req0_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin @(negedge clk); if (bus.req0_ready) begin ok = 1'b1; break; end end
    if (!ok) check("midrst_acc_timeout", 0, 1);
    @(posedge clk); @(posedge clk); @(posedge clk);
    #3 rst_n = 1'b0;
    @(posedge clk);
    #3 rst_n = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (bus.req0_ready) begin ok = 1'b1; break; end end
    if (!ok) check("midrst_reacc_timeout", 0, 1);
    @(posedge clk); #1 bus.req0_valid = 1'b0;
    wait_rsp();
    check("midrst_c", {bus.rsp_carry, bus.rsp_c}, 5'b10001);

    for (int n = 0; n < 30; n++) begin
      mode = $urandom_range(2, 0);
      if (mode == 2) begin
        fork
          issue(0, W'($urandom), W'($urandom), 3'($urandom_range(7, 0)));
          issue(1, W'($urandom), W'($urandom), 3'($urandom_range(7, 0)));
        join
      end else begin
        issue(mode, W'($urandom), W'($urandom), 3'($urandom_range(7, 0)));
      end
      repeat ($urandom_range(2, 0)) @(posedge clk);
      #1;
    end

    repeat (W + 4) @(posedge clk);
    @(negedge clk);
    check("drain_q", q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
